// File: rtl/onehot_scan_pkg.sv
// Shared mode encodings and FSM state type for the one-hot / thermometer / scan decoder.
package onehot_scan_pkg;

    localparam logic [1:0] MODE_DECODE = 2'd0;
    localparam logic [1:0] MODE_THERMO = 2'd1;
    localparam logic [1:0] MODE_SCAN   = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/onehot_scan_decoder_bin2onehot.sv
// Purely combinational binary index to one-hot converter.
module bin2onehot #(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]      idx_i,
    output logic [2**SEL_W-1:0]   onehot_o
);

    always_comb begin
        onehot_o        = '0;
        onehot_o[idx_i] = 1'b1;
    end

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered one-hot / thermometer decoder with a timed auto-scan mode.
// state    | meaning
// ST_IDLE  | decode/thermo follow sel each cycle; SCAN mode waits for start
// ST_SCAN  | walking one active bit over 0..last, each held dwell+1 cycles
module onehot_scan_decoder
    import onehot_scan_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [1:0]            mode_i,
    input  logic [SEL_W-1:0]      sel_i,
    input  logic                  start_i,
    input  logic [DWELL_W-1:0]    dwell_i,
    output logic [2**SEL_W-1:0]   out_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int OUT_W = 2**SEL_W;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     step_q, step_d;
    logic [SEL_W-1:0]     last_q, last_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [OUT_W-1:0]     out_q, out_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [SEL_W-1:0]     oh_idx;
    logic [OUT_W-1:0]     oh_vec;
    logic [OUT_W-1:0]     thermo_vec;

    // Single decoder: idle decodes sel (or index 0 on scan start), scan decodes the next step.
    always_comb begin
        oh_idx = sel_i;
        if (state_q == ST_SCAN) begin
            oh_idx = step_q + SEL_W'(1);
        end else if (mode_i == MODE_SCAN) begin
            oh_idx = '0;
        end
    end

    bin2onehot #(.SEL_W(SEL_W)) u_bin2onehot (
        .idx_i    (oh_idx),
        .onehot_o (oh_vec)
    );

    always_comb begin
        thermo_vec = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (i <= int'(sel_i)) thermo_vec[i] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                case (mode_i)
                    MODE_DECODE: out_d = oh_vec;
                    MODE_THERMO: out_d = thermo_vec;
                    MODE_SCAN: begin
                        out_d = '0;
                        if (start_i) begin
                            last_d  = sel_i;
                            dwell_d = dwell_i;
                            step_d  = '0;
                            cnt_d   = '0;
                            out_d   = oh_vec;
                            busy_d  = 1'b1;
                            state_d = ST_SCAN;
                        end
                    end
                    default: out_d = '0;
                endcase
            end
            ST_SCAN: begin
                // Compare before increment so an all-ones dwell never wraps.
                if (cnt_q == dwell_q) begin
                    cnt_d = '0;
                    if (step_q == last_q) begin
                        out_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        step_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        step_d = step_q + SEL_W'(1);
                        out_d  = oh_vec;
                    end
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (en_i) begin
            state_q <= state_d;
            step_q  <= step_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out_o  = out_q;
    assign busy_o = busy_q;
    // A pending done pulse is held while disabled and shows once en returns.
    assign done_o = done_q & en_i;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Directed self-checking bench for onehot_scan_decoder (SEL_W=3, DWELL_W=8).
module tb_onehot_scan_decoder;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       en_i;
    logic [1:0] mode_i;
    logic [2:0] sel_i;
    logic       start_i;
    logic [7:0] dwell_i;
    logic [7:0] out_o;
    logic       busy_o;
    logic       done_o;

    int checks = 0;
    int errors = 0;

    onehot_scan_decoder #(.SEL_W(3), .DWELL_W(8)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (en_i),
        .mode_i  (mode_i),
        .sel_i   (sel_i),
        .start_i (start_i),
        .dwell_i (dwell_i),
        .out_o   (out_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; en_i = 1'b1; mode_i = 2'd0; sel_i = 3'd5; start_i = 1'b0; dwell_i = 8'd0;
        tick(); tick();
        checks++; if (out_o !== 8'h00) begin errors++; $display("FAIL reset_out: got %h exp 00", out_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done_o); end
        rst_i = 1'b0;
        tick();
        checks++; if (out_o !== 8'h20) begin errors++; $display("FAIL reset_release: got %h exp 20", out_o); end
    endtask

    task automatic test_decode();
        logic [7:0] exp;
        mode_i = 2'd0;
        for (int i = 0; i < 8; i++) begin
            sel_i = 3'(i);
            exp   = 8'(1 << i);
            tick();
            checks++; if (out_o !== exp) begin errors++; $display("FAIL decode_sel%0d: got %h exp %h", i, out_o, exp); end
        end
        en_i = 1'b0; sel_i = 3'd2;
        tick(); tick();
        checks++; if (out_o !== 8'h80) begin errors++; $display("FAIL decode_en_hold: got %h exp 80", out_o); end
        en_i = 1'b1;
    endtask

    task automatic test_thermo();
        logic [2:0] sels [3] = '{3'd0, 3'd3, 3'd7};
        logic [7:0] exps [3] = '{8'h01, 8'h0F, 8'hFF};
        mode_i = 2'd1;
        for (int i = 0; i < 3; i++) begin
            sel_i = sels[i];
            tick();
            checks++; if (out_o !== exps[i]) begin errors++; $display("FAIL thermo_sel%0d: got %h exp %h", sels[i], out_o, exps[i]); end
        end
        mode_i = 2'd3;
        tick();
        checks++; if (out_o !== 8'h00) begin errors++; $display("FAIL rsvd_mode: got %h exp 00", out_o); end
    endtask

    task automatic test_scan_basic();
        logic [7:0] exp;
        mode_i = 2'd2; sel_i = 3'd3; dwell_i = 8'd2; start_i = 1'b0;
        tick();
        checks++; if (out_o !== 8'h00) begin errors++; $display("FAIL scan_idle_nostart: got %h exp 00", out_o); end
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int c = 0; c < 12; c++) begin
            exp = 8'(1 << (c / 3));
            checks++; if (out_o !== exp || busy_o !== 1'b1 || done_o !== 1'b0) begin
                errors++; $display("FAIL scan_basic_c%0d: got out=%h busy=%b done=%b exp out=%h busy=1 done=0", c, out_o, busy_o, done_o, exp);
            end
            tick();
        end
        checks++; if (out_o !== 8'h00 || busy_o !== 1'b0 || done_o !== 1'b1) begin
            errors++; $display("FAIL scan_basic_done: got out=%h busy=%b done=%b exp out=00 busy=0 done=1", out_o, busy_o, done_o);
        end
        tick();
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL scan_basic_done_pulse: got %b exp 0", done_o); end
    endtask

    task automatic test_scan_ignore();
        logic [7:0] exps [6] = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h04, 8'h04};
        mode_i = 2'd2; sel_i = 3'd2; dwell_i = 8'd1; start_i = 1'b1;
        tick();
        sel_i = 3'd7; dwell_i = 8'd5;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) begin mode_i = 2'd1; sel_i = 3'd0; start_i = 1'b0; end
            checks++; if (out_o !== exps[c] || busy_o !== 1'b1) begin
                errors++; $display("FAIL scan_ignore_c%0d: got out=%h busy=%b exp out=%h busy=1", c, out_o, busy_o, exps[c]);
            end
            tick();
        end
        checks++; if (out_o !== 8'h00 || done_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++; $display("FAIL scan_ignore_done: got out=%h busy=%b done=%b exp out=00 busy=0 done=1", out_o, busy_o, done_o);
        end
        mode_i = 2'd2;
        tick();
    endtask

    task automatic test_back_to_back();
        mode_i = 2'd2; sel_i = 3'd0; dwell_i = 8'd0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        checks++; if (out_o !== 8'h01 || busy_o !== 1'b1 || done_o !== 1'b0) begin
            errors++; $display("FAIL single_step: got out=%h busy=%b done=%b exp out=01 busy=1 done=0", out_o, busy_o, done_o);
        end
        tick();
        checks++; if (out_o !== 8'h00 || busy_o !== 1'b0 || done_o !== 1'b1) begin
            errors++; $display("FAIL single_done: got out=%h busy=%b done=%b exp out=00 busy=0 done=1", out_o, busy_o, done_o);
        end
        sel_i = 3'd1; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        checks++; if (out_o !== 8'h01 || busy_o !== 1'b1) begin
            errors++; $display("FAIL b2b_start: got out=%h busy=%b exp out=01 busy=1", out_o, busy_o);
        end
        tick();
        checks++; if (out_o !== 8'h02) begin errors++; $display("FAIL b2b_step1: got %h exp 02", out_o); end
        tick();
        checks++; if (done_o !== 1'b1 || out_o !== 8'h00) begin
            errors++; $display("FAIL b2b_done: got out=%h done=%b exp out=00 done=1", out_o, done_o);
        end
        en_i = 1'b0;
        #1;
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL done_masked: got %b exp 0", done_o); end
        tick(); tick();
        en_i = 1'b1;
        #1;
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL done_resumed: got %b exp 1", done_o); end
        tick();
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL done_cleared: got %b exp 0", done_o); end
    endtask

    task automatic test_reset_mid();
        mode_i = 2'd2; sel_i = 3'd3; dwell_i = 8'd1; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick(); tick(); tick(); tick();
        checks++; if (out_o !== 8'h04) begin errors++; $display("FAIL rst_mid_step2: got %h exp 04", out_o); end
        rst_i = 1'b1;
        tick();
        checks++; if (out_o !== 8'h00 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++; $display("FAIL rst_mid: got out=%h busy=%b done=%b exp out=00 busy=0 done=0", out_o, busy_o, done_o);
        end
        rst_i = 1'b0;
        tick();
        checks++; if (out_o !== 8'h00 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++; $display("FAIL rst_mid_after: got out=%h busy=%b done=%b exp out=00 busy=0 done=0", out_o, busy_o, done_o);
        end
    endtask

    task automatic test_enable_freeze();
        logic [7:0] exps [3] = '{8'h02, 8'h04, 8'h04};
        mode_i = 2'd2; sel_i = 3'd2; dwell_i = 8'd1; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick(); tick();
        checks++; if (out_o !== 8'h02) begin errors++; $display("FAIL freeze_step1: got %h exp 02", out_o); end
        en_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (out_o !== 8'h02 || busy_o !== 1'b1 || done_o !== 1'b0) begin
                errors++; $display("FAIL freeze_c%0d: got out=%h busy=%b done=%b exp out=02 busy=1 done=0", c, out_o, busy_o, done_o);
            end
        end
        en_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (out_o !== exps[c] || busy_o !== 1'b1) begin
                errors++; $display("FAIL freeze_resume_c%0d: got out=%h busy=%b exp out=%h busy=1", c, out_o, busy_o, exps[c]);
            end
        end
        tick();
        checks++; if (out_o !== 8'h00 || busy_o !== 1'b0 || done_o !== 1'b1) begin
            errors++; $display("FAIL freeze_done: got out=%h busy=%b done=%b exp out=00 busy=0 done=1", out_o, busy_o, done_o);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_thermo();
        test_scan_basic();
        test_scan_ignore();
        test_back_to_back();
        test_reset_mid();
        test_enable_freeze();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/onehot_scan_decoder.md
Name: onehot_scan_decoder

Overview:
Parametrised, registered successor to the team's 3-to-8 decoder. Decodes a SEL_W-bit select into a 2^SEL_W-bit output, in one of three modes:
- one-hot decode
- thermometer decode
- timed auto-scan that walks a single active bit across outputs 0..sel

Sits between control logic and row/LED/chip-select fan-out, where glitch-free registered outputs and a sequencing mode are required.

Parameters:
SEL_W, 3, select width; OUT_W = 2**SEL_W output lines (derived localparam, not overridable)
DWELL_W, 8, width of per-step dwell count in SCAN mode

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
en  in  1  global enable; 0 freezes all state and output
mode  in  2  0=DECODE, 1=THERMO, 2=SCAN, 3=reserved
sel  in  SEL_W  select index
start  in  1  SCAN trigger, sampled when en=1, mode=2, not busy
dwell  in  DWELL_W  SCAN: each step held dwell+1 cycles
out  out  OUT_W  registered decoded output
busy  out  1  high while a scan is in progress
done  out  1  one-cycle pulse on final scan step completion

Behaviour:
- One clock, synchronous active-high reset.
- Reset: out=0, busy=0, done=0, FSM=IDLE, step and dwell counters=0. Reset mid-scan aborts the scan; outputs are 0 on the cycle after rst is sampled.
- en=0: all registers hold, including out, counters and FSM; done is forced to 0 (no pulse lost, it fires once en returns).
- FSM states: IDLE, SCAN_RUN.
- IDLE, mode=0: out <= one-hot(sel), i.e. bit sel set. Latency 1 cycle from sel to out.
- IDLE, mode=1: out <= bits 0..sel set, e.g. sel=3 -> 0x0F. sel=OUT_W-1 gives all ones. Latency 1 cycle.
- IDLE, mode=3: out <= 0.
- IDLE, mode=2, start=0: out <= 0.
- IDLE, mode=2, start=1:
  - latch sel as last index and dwell as reload value
  - step <= 0, out <= one-hot(0), busy <= 1, go to SCAN_RUN
  - out=0x01 visible the cycle after start
- SCAN_RUN:
  - the dwell counter counts up to the latched dwell
  - when it reaches the latched dwell and step < last: step++, counter <= 0, out <= one-hot(step+1)
  - when it reaches the latched dwell and step == last: out <= 0, busy <= 0, done <= 1 for one cycle, go to IDLE
  - step k is visible for exactly dwell+1 cycles
  - total busy duration = (last+1)*(dwell+1) cycles
- During SCAN_RUN, mode, sel, dwell and start are ignored. A start while busy is dropped, not queued.
- Boundary cases:
  - sel=0 in SCAN: a single step, done after dwell+1 cycles
  - dwell=0: one cycle per step
  - dwell=all ones: 2^DWELL_W cycles per step, no counter overflow (compare-before-increment)
- done and the busy fall assert on the same edge. A start in the cycle where done=1 is accepted, because the FSM is already IDLE.
- out is always either one-hot, thermometer or zero; never multi-hot in DECODE or SCAN.
- All arithmetic is unsigned. The step counter is SEL_W bits and the dwell counter is DWELL_W bits; there is no wrap beyond last.

Decomposition:
- Package onehot_scan_pkg: mode localparams MODE_DECODE=2'd0, MODE_THERMO=2'd1, MODE_SCAN=2'd2, MODE_RSVD=2'd3; FSM state encodings ST_IDLE, ST_SCAN.
- Sub-module bin2onehot (parameter SEL_W): purely combinational, index -> one-hot. Instantiated once, with its input muxed between sel and step.
- Thermometer decode stays inline.

Test Plan (SEL_W=3, DWELL_W=8):
- Reset/idle: rst=1 for 2 cycles with mode=0, sel=5 -> out=0x00, busy=0, done=0; release rst -> out=0x20 one cycle later.
- DECODE sweep: mode=0, sel=0..7, en=1 -> out 0x01,0x02,...,0x80, each one cycle after its sel; then en=0, sel=2 -> out holds 0x80.
- THERMO: mode=1, sel=0,3,7 -> out 0x01, 0x0F, 0xFF.
- SCAN basic: mode=2, sel=3, dwell=2, start pulse -> out 0x01,0x02,0x04,0x08, each for 3 cycles; busy high 12 cycles; done=1 on the cycle out returns to 0x00.
- SCAN edges:
  - sel=0, dwell=0 -> out=0x01 for 1 cycle then done
  - start asserted mid-scan -> ignored
  - sel/dwell/mode changed mid-scan -> sequence unchanged
- Reset/enable mid-scan:
  - rst=1 at step 2 -> next cycle out=0, busy=0, no done
  - en=0 for 5 cycles at step 1 -> out and counters freeze; scan completes 5 cycles later than nominal
